// File: rtl/wb_regfile_pkg.sv
// Shared widths and constants for the writeback register file slice.
package wb_regfile_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned PCW  = 64;
    localparam int unsigned CNTW = 64;

    localparam logic [XLEN-1:0] ZERO_WORD = '0;
    localparam logic [AW-1:0]   ZERO_REG  = '0;
    localparam logic [PCW-1:0]  ZERO_PC   = '0;
    localparam logic [CNTW-1:0] ZERO_NUM  = '0;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

endpackage

// File: rtl/wb_regfile_core.sv
// Architectural integer register storage: one write port, two read ports with
// same-cycle write-through bypass. Index 0 always reads as zero.
module wb_regfile_core
    import wb_regfile_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            w_valid,
    input  logic            w_ena,
    input  logic [AW-1:0]   w_addr,
    input  logic [XLEN-1:0] w_data,
    input  logic [AW-1:0]   rs1_addr,
    output logic [XLEN-1:0] rs1_data,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs2_data,
    output logic            write_fire
);

    logic [XLEN-1:0] regs [NREG];

    assign write_fire = w_valid & w_ena & (w_addr != ZERO_REG);

    // x0 is never targeted by write_fire, so its entry stays at its reset value
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[AW'(i)] <= ZERO_WORD;
            end
        end else if (write_fire) begin
            regs[w_addr] <= w_data;
        end
    end

    always_comb begin
        rs1_data = regs[rs1_addr];
        if (rs1_addr == ZERO_REG) begin
            rs1_data = ZERO_WORD;
        end else if (write_fire && (rs1_addr == w_addr)) begin
            rs1_data = w_data;
        end
    end

    always_comb begin
        rs2_data = regs[rs2_addr];
        if (rs2_addr == ZERO_REG) begin
            rs2_data = ZERO_WORD;
        end else if (write_fire && (rs2_addr == w_addr)) begin
            rs2_data = w_data;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage consumer: register file plus registered commit record and
// retired-instruction counter for trace/difftest.
module wb_regfile
    import wb_regfile_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            wb_valid,
    input  logic            wb_w_ena,
    input  logic [AW-1:0]   wb_w_addr,
    input  logic [XLEN-1:0] wb_w_data,
    input  logic [PCW-1:0]  wb_pc,
    input  logic [AW-1:0]   rs1_addr,
    output logic [XLEN-1:0] rs1_data,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs2_data,
    output logic            commit_valid,
    output logic [PCW-1:0]  commit_pc,
    output logic            commit_wen,
    output logic [AW-1:0]   commit_rd,
    output logic [XLEN-1:0] commit_wdata,
    output logic [CNTW-1:0] instret
);

    logic write_fire;

    wb_regfile_core u_core (
        .clock      (clock),
        .reset      (reset),
        .w_valid    (wb_valid),
        .w_ena      (wb_w_ena),
        .w_addr     (wb_w_addr),
        .w_data     (wb_w_data),
        .rs1_addr   (rs1_addr),
        .rs1_data   (rs1_data),
        .rs2_addr   (rs2_addr),
        .rs2_data   (rs2_data),
        .write_fire (write_fire)
    );

    // Commit fields only move on a real retirement; bubbles just drop the pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            commit_valid <= DISABLE;
            commit_pc    <= ZERO_PC;
            commit_wen   <= DISABLE;
            commit_rd    <= ZERO_REG;
            commit_wdata <= ZERO_WORD;
            instret      <= ZERO_NUM;
        end else begin
            commit_valid <= wb_valid;
            if (wb_valid) begin
                commit_pc    <= wb_pc;
                commit_rd    <= wb_w_addr;
                commit_wen   <= write_fire;
                commit_wdata <= write_fire ? wb_w_data : ZERO_WORD;
                instret      <= instret + CNTW'(1);
            end
        end
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Consumer end of the MEM/WB writeback interface.
- Holds the architectural integer register file of the NPC core and accepts the write-back stream (enable, address, data, pc) from the MEM/WB pipeline register.
- Provides two combinational read ports to decode, with same-cycle write-through bypass.
- Produces a registered commit record and a retired-instruction counter for difftest/trace.

Parameters:
- XLEN, 64, data width of registers and write data
- NREG, 32, number of architectural registers (x0..x31)
- AW, 5, register address width; NREG == 2**AW
- PCW, 64, program counter width

Ports:
- clock  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- wb_valid  input  1  WB stage holds a real retiring instruction (0 = bubble)
- wb_w_ena  input  1  instruction writes rd
- wb_w_addr  input  AW  destination register index
- wb_w_data  input  XLEN  value to write
- wb_pc  input  PCW  pc of the retiring instruction
- rs1_addr  input  AW  read port 1 index
- rs1_data  output  XLEN  read port 1 data (combinational)
- rs2_addr  input  AW  read port 2 index
- rs2_data  output  XLEN  read port 2 data (combinational)
- commit_valid  output  1  one-cycle pulse, one instruction retired
- commit_pc  output  PCW  pc of the retired instruction
- commit_wen  output  1  the retired instruction wrote a non-x0 register
- commit_rd  output  AW  destination index of the retired instruction
- commit_wdata  output  XLEN  value written (0 when commit_wen = 0)
- instret  output  64  count of retired instructions

Behaviour:
- Reset is synchronous, active-high, on clock. While reset = 1 at a rising edge, all of the following are cleared:
  - all NREG registers to 0
  - commit_valid = 0, commit_pc = 0, commit_wen = 0, commit_rd = 0, commit_wdata = 0
  - instret = 0
- Reset has priority over any concurrent wb_valid; that instruction is dropped and not counted.
- Write:
  - Define do_write = wb_valid & wb_w_ena & (wb_w_addr != 0).
  - At a rising edge with do_write, reg[wb_w_addr] <= wb_w_data.
  - wb_w_ena with wb_valid = 0 is ignored entirely.
- x0:
  - Never written; storage for index 0 is constant 0.
  - A read of index 0 returns 0 regardless of bypass.
- Read ports:
  - Purely combinational, zero latency.
  - rsN_data = 0 if rsN_addr == 0; else wb_w_data if do_write & (rsN_addr == wb_w_addr); else reg[rsN_addr].
  - Both ports may address the same register, including the bypassed one; both return the identical value.
- Commit record:
  - One-cycle latency: the registered outputs reflect the WB inputs of the previous edge.
  - commit_valid <= wb_valid.
  - commit_pc, commit_rd, commit_wen, commit_wdata are captured when wb_valid = 1:
    - commit_wen <= do_write
    - commit_wdata <= do_write ? wb_w_data : 0
  - When wb_valid = 0, commit_valid <= 0 and the other commit fields hold their value.
- instret:
  - Increments by 1 on every edge with wb_valid = 1 and reset = 0.
  - Unsigned 64-bit; wraps from 2^64-1 to 0 without a flag.
- Back-to-back retirements (wb_valid every cycle) are supported at full rate, with one commit pulse per cycle.
- No X-propagation: every output is driven from reset onward.

Decomposition:
- Shared defines file: XLEN/AW/PCW widths, zero constants (zero reg, zero num, zero pc) and the enable/disable encodings, reusing the existing ysyx_22040931 macro set.
- One sub-module, regfile_core: the NREG x XLEN storage array with one write port and two bypassed read ports.
- The top level adds the commit record and instret logic.

Test Plan:
1. Reset: hold reset 2 cycles with wb_valid=1, wb_w_ena=1, addr=5, data=0xDEAD. Required: all regs read 0, commit_valid=0, instret=0.
2. Write then read: wb_valid=1, ena=1, addr=3, data=0x1234_5678_9ABC_DEF0, rs1_addr=3 in the same cycle. Required: rs1_data=0x1234_5678_9ABC_DEF0 via bypass. Next cycle (wb_valid=0): rs1_data still holds it from storage, commit_valid=1, commit_rd=3, commit_wen=1.
3. x0 protection: wb_valid=1, ena=1, addr=0, data=0xFFFF_FFFF_FFFF_FFFF, rs1_addr=rs2_addr=0. Required: both reads 0 that cycle and after; commit_wen=0, commit_wdata=0, instret incremented.
4. Bubble/ignored write: wb_valid=0, ena=1, addr=7, data=0x55. Required: reg x7 unchanged (0), commit_valid=0, instret unchanged.
5. Back-to-back: 4 consecutive valid writes to x1=1, x2=2, x1=3, x2=4 (pc 0x8000_0000 step 4), rs1=x1, rs2=x2 monitored. Required: four commit pulses with pc 0x8000_0000..0x8000_000C, final x1=3, x2=4, instret=4.
6. Mid-operation reset: reset asserted in the cycle of a valid write to x9=0x77. Required: x9=0, instret=0, commit_valid=0 afterwards.
